// File: rtl/rr_decoder_feeder.sv
// ---------------------------------------------------------------------------
// rr_decoder_feeder
//
// Round-robin arbiter that feeds a three_to_eight one-hot decoder. Eight
// request lines are arbitrated with a rotating priority pointer. The winner
// is presented as a registered index (decoder Inp) plus an enable
// (decoder E). The grant is held until the holder signals done or a hold
// timeout expires. After each grant there is one guaranteed idle cycle, so
// the decoder output is all zeros between grants.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset, highest priority
//   req[7:0]   request lines, bit i requests decoder output i
//   done       holder releases its grant (only looked at while a grant is held)
//   grant_idx  registered winning index -> decoder Inp
//   grant_en   registered grant valid   -> decoder E
//   timeout    one-cycle pulse when a grant is force-released by the timer
//
// Parameters:
//   HOLD_MAX   maximum grant length in cycles, 0 disables the timeout
//   CNT_W      hold counter width, HOLD_MAX must fit in CNT_W bits
// ---------------------------------------------------------------------------
module rr_decoder_feeder #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The counter value seen on the last allowed hold cycle. When the timeout
  // is disabled this constant is never used.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam bit TIMEOUT_ON = (HOLD_MAX != 0);

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       win_idx;
  logic             win_found;
  logic             hold_expired;

  // Search ptr, ptr+1, ... wrapping mod 8; the 3-bit add wraps naturally.
  // NOTE: every always_comb output gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && req[ptr + 3'(i)]) begin
        win_idx   = ptr + 3'(i);
        win_found = 1'b1;
      end
    end
  end

  assign hold_expired = TIMEOUT_ON && (cnt == HOLD_LAST);

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      grant_idx <= 3'd0;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_found) begin
            grant_idx <= win_idx;
            grant_en  <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end else begin
            // grant_idx keeps its last value while nothing is granted.
            grant_en <= 1'b0;
          end
        end

        BUSY: begin
          if (done || hold_expired) begin
            grant_en <= 1'b0;
            ptr      <= grant_idx + 3'd1;
            // done wins over a coincident timeout, so no pulse in that case.
            timeout  <= !done;
            state    <= GAP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          grant_en <= 1'b0;
          timeout  <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          grant_en <= 1'b0;
          timeout  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decoder_feeder.sv
// ---------------------------------------------------------------------------
// tb_rr_decoder_feeder
//
// Self-checking bench for rr_decoder_feeder with HOLD_MAX=16. Expected
// grant indices are pushed to a queue when the request pattern is driven and
// popped when the DUT raises grant_en. A small decoder model turns the grant
// into the one-hot vector the downstream three_to_eight would produce.
// ---------------------------------------------------------------------------
module tb_rr_decoder_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic [2:0] exp_idx;
  } vec_t;

  rr_decoder_feeder #(.HOLD_MAX(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Downstream three_to_eight decoder model.
  function automatic logic [7:0] decode(input logic [2:0] idx, input logic en);
    return en ? (8'b1 << idx) : 8'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next grant, then compare it with the scoreboard.
  task automatic wait_grant(input string name, input int exp_cycles);
    int         c;
    logic [2:0] exp_idx;
    c = 0;
    while (!grant_en && c < 8) begin
      tick();
      c++;
    end
    check({name, "_en"}, grant_en, 1);
    check({name, "_lat"}, c, exp_cycles);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      exp_idx = exp_q.pop_front();
      check({name, "_idx"}, grant_idx, exp_idx);
      check({name, "_dec"}, decode(grant_idx, grant_en), decode(exp_idx, 1'b1));
    end
  endtask

  // Pulse done for one edge and confirm a clean release.
  task automatic release_done(input string name);
    done = 1'b1;
    tick();
    done = 1'b0;
    check({name, "_rel_en"}, grant_en, 0);
    check({name, "_rel_to"}, timeout, 0);
    check({name, "_rel_dec"}, decode(grant_idx, grant_en), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   hi;
    int   early_to;

    vecs[0]  = '{8'hFF, 3'd1};
    vecs[1]  = '{8'hFF, 3'd2};
    vecs[2]  = '{8'hFF, 3'd3};
    vecs[3]  = '{8'hFF, 3'd4};
    vecs[4]  = '{8'hFF, 3'd5};
    vecs[5]  = '{8'hFF, 3'd6};
    vecs[6]  = '{8'hFF, 3'd7};
    vecs[7]  = '{8'hFF, 3'd0};
    vecs[8]  = '{8'b0010_0000, 3'd5};
    vecs[9]  = '{8'b1000_0000, 3'd7};
    vecs[10] = '{8'b1000_0001, 3'd0};
    vecs[11] = '{8'b1000_0001, 3'd7};
    vecs[12] = '{8'b1000_0001, 3'd0};
    vecs[13] = '{8'b1000_0001, 3'd7};

    // Reset with every request active.
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    tick();
    tick();
    check("rst_en", grant_en, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_to", timeout, 0);
    check("rst_dec", decode(grant_idx, grant_en), 8'h00);

    rst = 1'b0;
    exp_q.push_back(3'd0);
    wait_grant("first", 1);

    // Rotation, single request, fairness with wrap. Each entry is applied at
    // the release of the previous grant; arbitration happens two edges later.
    foreach (vecs[i]) begin
      req = vecs[i].req;
      exp_q.push_back(vecs[i].exp_idx);
      release_done($sformatf("vec%0d", i));
      wait_grant($sformatf("vec%0d", i), 2);
    end

    // Release into an empty IDLE; done while idle must be ignored.
    req = 8'h00;
    release_done("drain");
    done = 1'b1;
    tick();
    tick();
    tick();
    done = 1'b0;
    check("idle_done_en", grant_en, 0);

    // Timeout: grant held for exactly 16 cycles, then a one-cycle pulse.
    req = 8'b0000_0100;
    exp_q.push_back(3'd2);
    wait_grant("to_grant", 1);
    hi       = 1;
    early_to = 0;
    while (grant_en && hi < 40) begin
      tick();
      if (grant_en) begin
        hi++;
        if (timeout) early_to++;
      end
    end
    check("to_hold_len", hi, 16);
    check("to_no_early", early_to, 0);
    check("to_pulse", timeout, 1);
    check("to_gap_dec", decode(grant_idx, grant_en), 8'h00);
    tick();
    check("to_pulse_clear", timeout, 0);
    exp_q.push_back(3'd2);
    wait_grant("to_regrant", 1);

    // done coincident with the timeout cycle: release without a pulse.
    for (int i = 0; i < 15; i++) tick();
    check("dto_still_held", grant_en, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("dto_en", grant_en, 0);
    check("dto_to", timeout, 0);

    // Reset mid-BUSY: pointer is 3 here, so bits {1,4,6} grant 4 first.
    // After reset the pointer must be 0 and the next winner is 1.
    req = 8'b0101_0010;
    exp_q.push_back(3'd4);
    wait_grant("mid_pre", 2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_en", grant_en, 0);
    check("mid_rst_idx", grant_idx, 0);
    check("mid_rst_to", timeout, 0);
    rst = 1'b0;
    exp_q.push_back(3'd1);
    wait_grant("mid_post", 1);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
